instr_encoder: RTL
==================

# instr_encoder

Instruction encoder and loader: packs decoded instruction fields (format, opcode, funct, registers, signed immediate) into 32-bit RV32I words and writes them sequentially into instruction memory. It is the inverse of the core's immediate generator and instruction-field decode. It sits between the test/boot stimulus source and the instruction-memory write port. Immediate format codes match the core's ImmSrc encoding, so the core decodes every encoded word back to the same fields.

## Interface
Parameters:
- DEPTH, 256, instruction-memory capacity in words; load stops when reached
- BASE_ADDR, 32'h0000_0000, byte address of the first word written

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous restart: address, count and err return to reset values
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- fmt  in  2  00 I-type, 01 S-type, 10 B-type, 11 R-type
- opcode  in  7  opcode[6:0]
- funct3  in  3  funct3
- funct7  in  7  funct7 (R-type only)
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  signed immediate, byte offset for B-type
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  32  byte address of the word being written
- mem_wdata  out  32  encoded instruction
- count  out  $clog2(DEPTH)+1  words written since reset/clear
- full  out  1  count == DEPTH
- err  out  1  sticky: a bundle was rejected for an out-of-range immediate

## Operation
- States: LOAD (in_ready=1), FULL (in_ready=0).
- LOAD→FULL when the write that makes count reach DEPTH occurs.
- FULL→LOAD only on clear or rst.
- Accept = in_valid & in_ready. Unaccepted cycles have no effect; fields need not be held.
- Encoding:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
- Range check:
  - I/S: imm must lie in [-2048, 2047].
  - B: imm must lie in [-4096, 4094] and imm[0] must be 0.
  - R: imm is ignored.
  - Failure: the bundle is consumed (handshake completes), no write occurs, address and count do not advance, err sets and stays set.
- Address: first write goes to BASE_ADDR; each successful write adds 4.
- clear and an accept in the same cycle: clear wins and the bundle is dropped.
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0, in_ready=1.

## Timing
- Latency is 1 cycle. A bundle accepted at edge N produces mem_we=1, mem_addr and mem_wdata valid during the cycle after edge N. count increments at edge N.
- Throughput is one word per cycle while in LOAD; back-to-back accepts give consecutive write strobes.
- in_ready is a registered state decode, not combinational from in_valid.
- in_ready falls in the same cycle the last write (word DEPTH) is presented.
- rst or clear asserted while a write is pending: mem_we is 0 in the following cycle and no write is lost silently. The pending word is discarded by design.
- full is asserted exactly when in_ready is 0.

## Structure
- Shared package riscv_pkg:
  - format constants FMT_I=2'b00, FMT_S=2'b01, FMT_B=2'b10, FMT_R=2'b11 (shared with the core's ImmSrc decode)
  - RV32I opcode constants
- One combinational sub-module instr_pack:
  - inputs: fields
  - outputs: 32-bit word and imm_ok
- instr_encoder holds the state, address/count registers, output register and the sticky err flag.

## Test plan
- Reset, then I-type addi x1,x0,5 (opcode 0010011, funct3 0) → next cycle mem_we=1, mem_addr=0x0, mem_wdata=0x00500093, count=1.
- Back-to-back: S-type sw x2,8(x0) (opcode 0100011, funct3 010), then R-type add x3,x1,x2 (opcode 0110011) → consecutive strobes with 0x00202423 at 0x0 and 0x002081B3 at 0x4.
- B-type beq x0,x0,-4 (opcode 1100011) → 0xFE000EE3. Then B imm=3 → no write, err=1, count unchanged; a following valid bundle writes at the unchanged address.
- I-type imm=2048 → rejected, err=1. imm=-2048 → accepted, wdata[31:20]=0x800.
- DEPTH=4: send 5 bundles → 4 writes at 0x0–0xC, full=1 and in_ready=0 after the 4th, 5th bundle never accepted. clear → count=0, next write at BASE_ADDR.
- rst in the cycle after an accept → mem_we=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: immediate-format codes (same values as the core's
// ImmSrc decode), base opcodes, and the loader state type.
package riscv_pkg;

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_R = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        ENC_LOAD = 1'b0,
        ENC_FULL = 1'b1
    } enc_state_t;

    // True when bits [31:top] of imm are all copies of the sign bit, i.e. imm is
    // representable as a (top+1)-bit two's-complement value.
    function automatic logic imm_fits(input logic [31:0] imm, input int unsigned top);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = top; i < 32; i++) begin
            if (imm[i] != imm[31]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: assembles one RV32I word from decoded fields and flags
// immediates that the chosen format cannot represent.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        imm_ok
);

    always_comb begin
        word   = 32'h0;
        imm_ok = 1'b1;
        case (fmt)
            FMT_I: begin
                word   = {imm[11:0], rs1, funct3, rd, opcode};
                imm_ok = imm_fits(imm, 11);
            end
            FMT_S: begin
                word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                imm_ok = imm_fits(imm, 11);
            end
            FMT_B: begin
                // Branch offsets are halfword-aligned, so imm[0] is not encoded.
                word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                imm_ok = imm_fits(imm, 12) & ~imm[0];
            end
            default: begin
                word   = {funct7, rs2, rs1, funct3, rd, opcode};
                imm_ok = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction loader: accepts field bundles, encodes them and writes consecutive
// words into instruction memory starting at BASE_ADDR until DEPTH words are stored.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 fmt,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 funct3,
    input  logic [6:0]                 funct7,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [31:0]                imm,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH) + 1;

    enc_state_t     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    addr_q, addr_d;
    logic           err_q, err_d;
    logic           we_q, we_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    wdata_q, wdata_d;

    logic [31:0]    pack_word;
    logic           pack_ok;
    logic           accept;

    instr_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm    (imm),
        .word   (pack_word),
        .imm_ok (pack_ok)
    );

    // Handshake: a bundle transfers on any cycle where in_valid and in_ready are both
    // high; in_ready depends only on registered state, never on in_valid.
    assign accept = in_valid & (state_q == ENC_LOAD);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        err_d      = err_q;
        we_d       = 1'b0;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        if (clear) begin
            state_d    = ENC_LOAD;
            count_d    = '0;
            addr_d     = BASE_ADDR;
            err_d      = 1'b0;
            mem_addr_d = BASE_ADDR;
            wdata_d    = 32'h0;
        end else if (accept) begin
            if (pack_ok) begin
                we_d       = 1'b1;
                mem_addr_d = addr_q;
                wdata_d    = pack_word;
                addr_d     = addr_q + 32'd4;
                count_d    = count_q + 1'b1;
                if (count_q == CW'(DEPTH - 1)) begin
                    state_d = ENC_FULL;
                end
            end else begin
                // Rejected bundle is still consumed; only the sticky flag records it.
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ENC_LOAD;
            count_q    <= '0;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign in_ready  = (state_q == ENC_LOAD);
    assign full      = (state_q == ENC_FULL);
    assign count     = count_q;
    assign err       = err_q;
    assign mem_we    = we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wdata_q;

endmodule
